// File: rtl/data_mem_responder.sv
// ============================================================================
// data_mem_responder
// ----------------------------------------------------------------------------
// Data-memory responder for the pipeline's memory stage. It accepts one
// load/store request at a time over a valid/ready channel, waits LATENCY
// cycles, performs an RV32I byte/half/word access with lane masking and
// sign/zero extension, and returns read data or an error over a valid/ready
// response channel. Stores also produce a response (rdata = 0) to signal
// completion.
//
// Parameters
//   ADDR_WIDTH : word-index bits, depth = 2**ADDR_WIDTH 32-bit words
//   LATENCY    : wait cycles between acceptance and memory access (0..15)
//
// Ports
//   clk         : clock, rising edge
//   rst         : asynchronous, active-low reset
//   req_valid   : request present
//   req_ready   : responder idle and able to accept a request
//   req_we      : 1 = store, 0 = load
//   req_funct3  : RV32I width/sign code
//   req_addr    : byte address (upper bits ignored, addresses alias)
//   req_wdata   : store data, right-aligned
//   resp_valid  : response present
//   resp_ready  : initiator accepts the response
//   resp_rdata  : extended load data; 0 for stores and errors
//   resp_err    : misaligned access or illegal funct3
//   busy        : responder is not idle
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    we_reg;
    logic [2:0]              funct3_reg;
    logic [ADDR_WIDTH+1:0]   addr_reg;
    logic [31:0]             wdata_reg;
    logic                    resp_valid_reg;
    logic [31:0]             resp_rdata_reg;
    logic                    resp_err_reg;

    // Address bits above the aliasing window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:ADDR_WIDTH+2]};

    assign req_ready  = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

    logic accept;
    assign accept = req_valid && req_ready;

    // With LATENCY = 0 the access happens on the acceptance edge, so the
    // decode must look at the live request rather than the latched copy.
    logic                  use_req;
    logic                  acc_we;
    logic [2:0]            acc_funct3;
    logic [ADDR_WIDTH+1:0] acc_addr;
    logic [31:0]           acc_wdata;

    assign use_req    = (state_reg == IDLE);
    assign acc_we     = use_req ? req_we                  : we_reg;
    assign acc_funct3 = use_req ? req_funct3              : funct3_reg;
    assign acc_addr   = use_req ? req_addr[ADDR_WIDTH+1:0] : addr_reg;
    assign acc_wdata  = use_req ? req_wdata               : wdata_reg;

    // Access edge: acceptance edge when LATENCY = 0, otherwise the last WAIT
    // cycle. Gated by rst so nothing is written while reset is held.
    logic do_access;
    assign do_access = rst && (((LATENCY == 0) && accept) ||
                               ((state_reg == WAIT) && (cnt_reg == 4'd1)));

    logic [ADDR_WIDTH-1:0] idx;
    assign idx = acc_addr[ADDR_WIDTH+1:2];

    // ------------------------------------------------------------------
    // Access decode: error detection, store lane enables, load extension
    // ------------------------------------------------------------------
    logic        code_legal;
    logic        misaligned;
    logic        acc_err;
    logic [3:0]  byte_en;
    logic [31:0] lane_wdata;
    logic [31:0] rd_word;
    logic [31:0] rd_shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] resp_data_next;
    logic        write_en;

    always_comb begin
        // Width code 11 is never legal; loads additionally allow the
        // unsigned byte/half forms (funct3[2] set) but not 110/111.
        if (acc_we)
            code_legal = (acc_funct3[1:0] != 2'b11) && !acc_funct3[2];
        else
            code_legal = (acc_funct3[1:0] != 2'b11) &&
                         !(acc_funct3[2] && acc_funct3[1]);

        case (acc_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = acc_addr[0];
            2'b10:   misaligned = (acc_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase

        acc_err = !code_legal || misaligned;

        case (acc_funct3[1:0])
            2'b00:   byte_en = 4'b0001 << acc_addr[1:0];
            2'b01:   byte_en = acc_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase

        // Replicate the store data so every enabled lane sees its bytes.
        case (acc_funct3[1:0])
            2'b00:   lane_wdata = {4{acc_wdata[7:0]}};
            2'b01:   lane_wdata = {2{acc_wdata[15:0]}};
            default: lane_wdata = acc_wdata;
        endcase

        rd_shifted = rd_word >> {acc_addr[1:0], 3'b000};
        rd_byte    = rd_shifted[7:0];
        rd_half    = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (acc_funct3)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase

        resp_data_next = (acc_we || acc_err) ? 32'd0 : load_data;
        write_en       = do_access && acc_we && !acc_err;
    end

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane so byte enables need no
    // read-modify-write. Not touched by rst.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clk) begin
                if (write_en && byte_en[gi])
                    lane_mem[idx] <= lane_wdata[gi*8 +: 8];
            end

            assign rd_word[gi*8 +: 8] = lane_mem[idx];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM with registered response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            we_reg         <= 1'b0;
            funct3_reg     <= 3'd0;
            addr_reg       <= '0;
            wdata_reg      <= 32'd0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg     <= req_we;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr[ADDR_WIDTH+1:0];
                        wdata_reg  <= req_wdata;
                        if (LATENCY == 0) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_rdata_reg <= resp_data_next;
                            resp_err_reg   <= acc_err;
                        end else begin
                            cnt_reg   <= 4'(LATENCY);
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd1) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= resp_data_next;
                        resp_err_reg   <= acc_err;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    // No acceptance on this edge: req_ready is only raised
                    // once the state is back in IDLE.
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_rdata_reg <= 32'd0;
                        resp_err_reg   <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
